// File: rtl/led_pkg.sv
// Shared constants for the LED breathing controller: mode encodings, ramp direction
// and the width helper for the active-channel index.
package led_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SEQ    = 2'd1;
  localparam logic [1:0] MODE_SYNC   = 2'd2;
  localparam logic [1:0] MODE_STATIC = 2'd3;

  typedef enum logic {
    DIR_RISE = 1'b0,
    DIR_FALL = 1'b1
  } dir_t;

  // A single channel still needs a one-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pwm_slice.sv
// One PWM output bit: compares the shared counter against the channel duty.
// LED_BREATHE_GAMMA_EN selects a quadratic level-to-duty curve instead of linear.
module led_pwm_slice #(
  parameter int WIDTH      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_level,
  output logic             o_pwm
);

  logic [WIDTH-1:0] duty;

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*WIDTH-1:0] square;
  assign square = {{WIDTH{1'b0}}, i_level} * {{WIDTH{1'b0}}, i_level};
  assign duty   = square[2*WIDTH-1:WIDTH];
`else
  assign duty = i_level;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pwm <= ACTIVE_LOW;
    end else begin
      o_pwm <= (i_cnt < duty) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_breathe_seq.sv
// N-channel LED breathing controller: prescaler, shared RISE/FALL ramp, per-channel
// levels and PWM slices. Optional LED_BREATHE_GAMMA_EN applies a quadratic duty curve.
module led_breathe_seq
  import led_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int PEAK       = 32,
  parameter int PRESCALE   = 256,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CH_W      = clog2_min1(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [1:0]                i_mode,
  input  logic [CHANNELS*WIDTH-1:0] i_static_level,
  output logic [CHANNELS-1:0]       o_pwm,
  output logic [CHANNELS*WIDTH-1:0] o_level,
  output logic [CH_W-1:0]           o_active_ch,
  output logic                      o_cycle_done
);

  localparam int               PS_W    = clog2_min1(PRESCALE);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PEAK_W  = WIDTH'(PEAK);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] pwm_cnt;
  logic [PS_W-1:0]  presc;
  logic [1:0]       mode_q;
  dir_t             dir;
  logic [CH_W-1:0]  ch;
  logic [WIDTH-1:0] level [CHANNELS];
  logic             tick;

  logic [WIDTH-1:0] cur_level;
  logic [WIDTH-1:0] ramp_next;
  dir_t             dir_next;
  logic             turn;
  logic [CH_W-1:0]  ch_next;

  assign tick = (presc == PS_LAST);

  // SEQ ramps the active channel; SYNC keeps the shared ramp in every channel, so read channel 0.
  always_comb begin
    cur_level = (mode_q == MODE_SEQ) ? level[ch] : level[0];
    ch_next   = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
    ramp_next = cur_level;
    dir_next  = dir;
    turn      = 1'b0;
    if (dir == DIR_RISE) begin
      if (cur_level == PEAK_W) begin
        dir_next  = DIR_FALL;
        ramp_next = cur_level - ONE;
      end else begin
        ramp_next = cur_level + ONE;
      end
    end else if (cur_level != '0) begin
      ramp_next = cur_level - ONE;
    end else begin
      dir_next = DIR_RISE;
      turn     = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q       <= MODE_OFF;
      presc        <= '0;
      dir          <= DIR_RISE;
      ch           <= '0;
      o_cycle_done <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) level[c] <= '0;
    end else begin
      o_cycle_done <= 1'b0;
      if (i_mode != mode_q) begin
        mode_q <= i_mode;
        presc  <= '0;
        dir    <= DIR_RISE;
        ch     <= '0;
        for (int c = 0; c < CHANNELS; c++) level[c] <= '0;
      end else begin
        if (i_enable) presc <= tick ? '0 : presc + PS_W'(1);
        case (mode_q)
          MODE_OFF: begin
            dir <= DIR_RISE;
            ch  <= '0;
            for (int c = 0; c < CHANNELS; c++) level[c] <= '0;
          end
          MODE_STATIC: begin
            for (int c = 0; c < CHANNELS; c++) begin
              level[c] <= (i_static_level[c*WIDTH +: WIDTH] > PEAK_W) ?
                          PEAK_W : i_static_level[c*WIDTH +: WIDTH];
            end
          end
          MODE_SEQ: begin
            if (i_enable && tick) begin
              dir <= dir_next;
              if (turn) begin
                ch             <= ch_next;
                level[ch_next] <= level[ch_next] + ONE;
                o_cycle_done   <= (ch == CH_LAST);
              end else begin
                level[ch] <= ramp_next;
              end
            end
          end
          default: begin
            if (i_enable && tick) begin
              dir          <= dir_next;
              o_cycle_done <= turn;
              for (int c = 0; c < CHANNELS; c++) level[c] <= turn ? ONE : ramp_next;
            end
          end
        endcase
      end
    end
  end

  assign o_active_ch = ch;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign o_level[c*WIDTH +: WIDTH] = level[c];

    led_pwm_slice #(
      .WIDTH      (WIDTH),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_slice (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_cnt     (pwm_cnt),
      .i_level   (level[c]),
      .o_pwm     (o_pwm[c])
    );
  end

endmodule

// File: tb/tb_led_breathe_seq.sv
// Directed bench for led_breathe_seq: two instances (active-low and active-high PWM)
// share inputs; covers reset, SEQ, enable hold, SYNC switch, STATIC saturation and OFF.
module tb_led_breathe_seq;
  import led_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] staticLevel;

  logic [2:0]  pwmLo, pwmHi;
  logic [23:0] levelLo, levelHi;
  logic [1:0]  activeLo, activeHi;
  logic        doneLo, doneHi;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  led_breathe_seq #(
    .CHANNELS(3), .WIDTH(8), .PEAK(4), .PRESCALE(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_reset_n(rstN), .i_enable(enable), .i_mode(mode),
    .i_static_level(staticLevel), .o_pwm(pwmLo), .o_level(levelLo),
    .o_active_ch(activeLo), .o_cycle_done(doneLo)
  );

  led_breathe_seq #(
    .CHANNELS(3), .WIDTH(8), .PEAK(4), .PRESCALE(2), .ACTIVE_LOW(1'b0)
  ) dutHi (
    .i_clk(clk), .i_reset_n(rstN), .i_enable(enable), .i_mode(mode),
    .i_static_level(staticLevel), .o_pwm(pwmHi), .o_level(levelHi),
    .o_active_ch(activeHi), .o_cycle_done(doneHi)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic en, input logic [23:0] lvl);
    mode        = m;
    enable      = en;
    staticLevel = lvl;
  endtask

  // Ramp shape seen by one channel over eight consecutive ticks.
  function automatic int expLvl(input int k);
    int p;
    p = (k - 1) % 8;
    return (p < 4) ? p + 1 : 7 - p;
  endfunction

  function automatic int expDuty(input int lvl);
`ifdef LED_BREATHE_GAMMA_EN
    return (lvl * lvl) >> 8;
`else
    return lvl;
`endif
  endfunction

  initial begin
    int chIdx;
    int cntA, cntB, cntC, cntD;
    rstN = 1'b0;
    applyStimulus(MODE_SEQ, 1'b1, 24'h0);
    #12;
    checkOutput("reset_pwm_lo", {29'd0, pwmLo}, 32'h7);
    checkOutput("reset_pwm_hi", {29'd0, pwmHi}, 32'h0);
    checkOutput("reset_level", {8'd0, levelLo}, 32'h0);
    checkOutput("reset_active", {30'd0, activeLo}, 32'h0);
    checkOutput("reset_done", {31'd0, doneLo}, 32'h0);

    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("seq_start_level", {8'd0, levelLo}, 32'h0);

    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      checkOutput($sformatf("seq_gap_done_%0d", k), {31'd0, doneLo}, 32'h0);
      @(negedge clk);
      chIdx = ((k - 1) / 8) % 3;
      checkOutput($sformatf("seq_level_%0d", k), {8'd0, levelLo},
                  32'(expLvl(k)) << (8 * chIdx));
      checkOutput($sformatf("seq_active_%0d", k), {30'd0, activeLo}, 32'(chIdx));
      checkOutput($sformatf("seq_done_%0d", k), {31'd0, doneLo}, {31'd0, k == 25});
      if (k == 3) begin
        applyStimulus(MODE_SEQ, 1'b0, 24'h0);
        cntA = 0;
        cntB = 0;
        for (int i = 0; i < 256; i++) begin
          @(negedge clk);
          if (!pwmLo[0]) cntA++;
          if (pwmHi[0]) cntB++;
        end
        checkOutput("hold_level", {8'd0, levelLo}, 32'h3);
        checkOutput("hold_pwm_lo_low", 32'(cntA), 32'(expDuty(3)));
        checkOutput("hold_pwm_hi_high", 32'(cntB), 32'(expDuty(3)));
        applyStimulus(MODE_SEQ, 1'b1, 24'h0);
      end
    end

    applyStimulus(MODE_SYNC, 1'b1, 24'h0);
    @(negedge clk);
    checkOutput("sync_clear_level", {8'd0, levelLo}, 32'h0);
    checkOutput("sync_clear_active", {30'd0, activeLo}, 32'h0);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      @(negedge clk);
      checkOutput($sformatf("sync_level_%0d", j), {8'd0, levelLo},
                  32'(expLvl(j)) * 32'h010101);
      checkOutput($sformatf("sync_done_%0d", j), {31'd0, doneLo},
                  {31'd0, (j > 1) && ((j - 1) % 8 == 0)});
    end

    applyStimulus(MODE_STATIC, 1'b1, {8'd0, 8'd200, 8'd2});
    @(negedge clk);
    checkOutput("static_clear", {8'd0, levelLo}, 32'h0);
    @(negedge clk);
    checkOutput("static_level", {8'd0, levelHi}, 32'h000402);
    cntA = 0; cntB = 0; cntC = 0; cntD = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwmHi[0]) cntA++;
      if (pwmHi[1]) cntB++;
      if (pwmHi[2]) cntC++;
      if (!pwmLo[0]) cntD++;
    end
    checkOutput("static_pwm0_high", 32'(cntA), 32'(expDuty(2)));
    checkOutput("static_pwm1_high", 32'(cntB), 32'(expDuty(4)));
    checkOutput("static_pwm2_high", 32'(cntC), 32'h0);
    checkOutput("static_pwm0_lo_low", 32'(cntD), 32'(expDuty(2)));

    applyStimulus(MODE_STATIC, 1'b0, {8'd4, 8'd1, 8'd3});
    @(negedge clk);
    checkOutput("static_no_enable", {8'd0, levelLo}, 32'h040103);

    applyStimulus(MODE_OFF, 1'b1, 24'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("off_level", {8'd0, levelLo}, 32'h0);
    checkOutput("off_pwm_lo", {29'd0, pwmLo}, 32'h7);

    applyStimulus(MODE_SEQ, 1'b1, 24'h0);
    repeat (7) @(negedge clk);
    checkOutput("midramp_level", {8'd0, levelLo}, 32'h3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midreset_pwm_lo", {29'd0, pwmLo}, 32'h7);
    checkOutput("midreset_level", {8'd0, levelLo}, 32'h0);
    checkOutput("midreset_active", {30'd0, activeLo}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
